// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the 32-bit pipeline to 16-bit SRAM sequencer.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_WR_LO,
      ST_WR_HI,
      ST_DONE
   } state_e;

   localparam logic HALF_LO = 1'b0;   // SRAM_ADDR[0] selecting bits [15:0]
   localparam logic HALF_HI = 1'b1;   // SRAM_ADDR[0] selecting bits [31:16]

   localparam int SRAM_AW = 18;       // 256K half-words
   localparam int DW      = 32;       // pipeline word
   localparam int HW      = 16;       // SRAM data width
   localparam int IDXW    = 17;       // word index = address[18:2]
   localparam int CNTW    = 3;        // phase counter, WAIT_CYCLES 0..7

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and sram_ctrl.
interface sram_ctrl_if;
   import sram_ctrl_pkg::*;

   logic          rd_en;
   logic          wr_en;
   logic [DW-1:0] address;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          ready;

   // pipeline side
   modport master (output rd_en, wr_en, address, write_data,
                   input  read_data, ready);

   // controller side
   modport slave  (input  rd_en, wr_en, address, write_data,
                   output read_data, ready);
endinterface

// File: rtl/sram_ctrl_phase_timer.sv
// Half-word phase timer: counts 0..WAIT_CYCLES while a phase runs and pulses
// done on the last cycle; wrapping to 0 on done starts the next phase cleanly.
module sram_phase_timer
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,   // a phase is in progress
   input  logic            clr_i,     // force count back to 0
   output logic            done_o,    // last cycle of the current phase
   output logic [CNTW-1:0] cnt_o
);

   localparam logic [CNTW-1:0] LAST = CNTW'(WAIT_CYCLES);

   logic [CNTW-1:0] cnt_q, cnt_d;

   // next count: clear outside phases, wrap at the phase boundary
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (start_i)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 3'd1;
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign done_o = start_i & ~clr_i & (cnt_q == LAST);
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/sram_ctrl.sv
// Sequences 32-bit loads/stores onto a 256Kx16 SRAM as two half-word phases,
// stalling the pipeline through ready. Optional one-entry read buffer under
// the SRAM_CTRL_READ_BUF_EN macro.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   sram_ctrl_if.slave         bus,
   inout  wire  [HW-1:0]      SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N
);

   localparam logic [CNTW-1:0] LAST = CNTW'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic              in_phase, is_rd, is_wr, is_hi;
   logic              ph_done;
   logic [CNTW-1:0]   cnt;
   logic [IDXW-1:0]   idx;
   logic [HW-1:0]     dq_out;
   logic [DW-1:0]     rd_data_q;
   logic              buf_hit;
   logic              unused_addr;

   assign idx         = bus.address[18:2];
   assign unused_addr = ^{bus.address[31:19], bus.address[1:0]};

   assign is_rd    = (state_q == ST_RD_LO) | (state_q == ST_RD_HI);
   assign is_wr    = (state_q == ST_WR_LO) | (state_q == ST_WR_HI);
   assign is_hi    = (state_q == ST_RD_HI) | (state_q == ST_WR_HI);
   assign in_phase = is_rd | is_wr;

   sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start_i (in_phase),
      .clr_i   (~in_phase),
      .done_o  (ph_done),
      .cnt_o   (cnt)
   );

`ifdef SRAM_CTRL_READ_BUF_EN
   logic            buf_vld_q;
   logic [IDXW-1:0] buf_tag_q;
   logic [DW-1:0]   buf_data_q;

   assign buf_hit = buf_vld_q & (buf_tag_q == idx);

   // buffer fill on every completed SRAM read, drop on any write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_vld_q  <= 1'b0;
         buf_tag_q  <= '0;
         buf_data_q <= '0;
      end else if (state_q == ST_WR_LO) begin
         buf_vld_q  <= 1'b0;
      end else if (state_q == ST_RD_HI && ph_done) begin
         buf_vld_q  <= 1'b1;
         buf_tag_q  <= idx;
         buf_data_q <= {SRAM_DQ, rd_data_q[HW-1:0]};
      end
   end
`else
   assign buf_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next state: store beats load; a buffered load skips the SRAM
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.wr_en)      state_d = ST_WR_LO;
            else if (bus.rd_en) state_d = buf_hit ? ST_DONE : ST_RD_LO;
         end
         ST_RD_LO: if (ph_done) state_d = ST_RD_HI;
         ST_RD_HI: if (ph_done) state_d = ST_DONE;
         ST_WR_LO: if (ph_done) state_d = ST_WR_HI;
         ST_WR_HI: if (ph_done) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // pin drive and handshake, all decoded from state and phase count
   always_comb begin
      bus.ready = ((state_q == ST_IDLE) & ~bus.rd_en & ~bus.wr_en) |
                  (state_q == ST_DONE);
      SRAM_ADDR = in_phase ? {idx, (is_hi ? HALF_HI : HALF_LO)} : '0;
      SRAM_OE_N = ~is_rd;
      // release WE one cycle before the address moves, unless there is no slack
      SRAM_WE_N = ~(is_wr & ((WAIT_CYCLES == 0) | (cnt < LAST)));
      dq_out    = is_hi ? bus.write_data[DW-1:HW] : bus.write_data[HW-1:0];
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_CE_N = 1'b0;
   end

   assign SRAM_DQ = is_wr ? dq_out : 'z;

   // load data capture: each half on the last cycle of its phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data_q <= '0;
      else if (state_q == ST_RD_LO && ph_done)
         rd_data_q[HW-1:0] <= SRAM_DQ;
      else if (state_q == ST_RD_HI && ph_done)
         rd_data_q[DW-1:HW] <= SRAM_DQ;
`ifdef SRAM_CTRL_READ_BUF_EN
      else if (state_q == ST_IDLE && bus.rd_en && !bus.wr_en && buf_hit)
         rd_data_q <= buf_data_q;
`endif
   end

   assign bus.read_data = rd_data_q;

endmodule
